servo_seq_ctrl: RTL

- Command sequencer in front of servo_driver; drives its 3-bit angle_idx input.
- Accepts target-angle commands over a valid/ready handshake.
- Ramps angle_idx one position at a time, aligned to a 20 ms frame timebase, then holds for a commanded number of frames before reporting done.
- Morse/display logic issues commands; servo_driver only ever sees angle_idx in range 0..4.

---
 rtl/servo_pkg.sv | 23 ++
 rtl/servo_frame_timer.sv | 31 +++
 rtl/servo_seq_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// servo_pkg - angle indices, FSM state type, timebase default (rev 1.0)
// ------------------------------------------------------------------
package servo_pkg;

  localparam logic [2:0] ANG_0   = 3'd0;
  localparam logic [2:0] ANG_45  = 3'd1;
  localparam logic [2:0] ANG_90  = 3'd2;
  localparam logic [2:0] ANG_135 = 3'd3;
  localparam logic [2:0] ANG_180 = 3'd4;
  localparam logic [2:0] ANG_MAX = ANG_180;

  localparam int FRAME_CYCLES_50M = 1_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/servo_frame_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// servo_frame_timer - free-running frame counter, one-cycle tick (rev 1.0)
// ------------------------------------------------------------------
module servo_frame_timer #(
  parameter int FRAME_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);

  localparam int              CW   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign frame_tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/servo_seq_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// servo_seq_ctrl - frame-aligned angle command sequencer (rev 1.0)
// Define SERVO_CMD_FIFO_EN to queue up to FIFO_DEPTH commands.
// ------------------------------------------------------------------
module servo_seq_ctrl #(
  parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES_50M,
  parameter int STEP_FRAMES  = 5,
  parameter int HOME_IDX     = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_angle,
  input  logic [7:0] cmd_hold,
  input  logic       abort,
  output logic [2:0] angle_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);
  import servo_pkg::*;

  localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);
  localparam logic [2:0] HOME      = 3'(HOME_IDX);

  if (STEP_FRAMES < 1 || STEP_FRAMES > 255) begin : g_bad_step
    $error("servo_seq_ctrl: STEP_FRAMES must be 1..255");
  end
  if (HOME_IDX < 0 || HOME_IDX > 4) begin : g_bad_home
    $error("servo_seq_ctrl: HOME_IDX must be 0..4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("servo_seq_ctrl: FIFO_DEPTH must be a power of 2, at least 2");
  end

  state_t     state, state_nxt;
  logic [2:0] target;
  logic [7:0] hold_cnt;
  logic [7:0] step_cnt;
  logic       frame_tick;

  // Command source: either the handshake directly or the queue head
  logic       src_avail;
  logic [2:0] src_angle;
  logic [7:0] src_hold;
  logic       reject;

  logic       take, step_en, hold_en, finish;

  servo_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_frame_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick)
  );

`ifdef SERVO_CMD_FIFO_EN
  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

  logic [10:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty, push;

  assign fifo_full  = (fifo_cnt == DEPTH);
  assign fifo_empty = (fifo_cnt == '0);
  assign cmd_ready  = !fifo_full && !abort;
  assign push       = cmd_valid && cmd_ready && (cmd_angle <= ANG_MAX);
  assign reject     = cmd_valid && cmd_ready && (cmd_angle > ANG_MAX);
  assign src_avail  = !fifo_empty;
  assign {src_angle, src_hold} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_angle, cmd_hold};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (abort) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (take) rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt <= fifo_cnt + (AW + 1)'(push) - (AW + 1)'(take);
    end
  end
`else
  assign cmd_ready = (state == IDLE) && !abort;
  assign reject    = cmd_valid && cmd_ready && (cmd_angle > ANG_MAX);
  assign src_avail = cmd_valid && cmd_ready && (cmd_angle <= ANG_MAX);
  assign src_angle = cmd_angle;
  assign src_hold  = cmd_hold;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (src_avail) state_nxt = MOVE;
        MOVE:    if (angle_idx == target) state_nxt = HOLD;
        HOLD:    if (hold_cnt == 8'd0) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state != IDLE);
    take    = (state == IDLE) && src_avail && !abort;
    step_en = (state == MOVE) && !abort && (angle_idx != target) && frame_tick;
    hold_en = (state == HOLD) && !abort && (hold_cnt != 8'd0) && frame_tick;
    finish  = (state == HOLD) && !abort && (hold_cnt == 8'd0);
  end

  // Steps only on frame_tick, so the driver never sees a change mid-frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_idx <= HOME;
      target    <= HOME;
      hold_cnt  <= '0;
      step_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= finish;
      err  <= reject;
      if (take) begin
        target   <= src_angle;
        hold_cnt <= src_hold;
        step_cnt <= '0;
      end else if (step_en) begin
        if (step_cnt == STEP_LAST) begin
          step_cnt  <= '0;
          angle_idx <= (target > angle_idx) ? angle_idx + 3'd1 : angle_idx - 3'd1;
        end else begin
          step_cnt <= step_cnt + 8'd1;
        end
      end else if (hold_en) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
